// File: rtl/pong_pkg.sv
// Shared types and constants for the Ping-Pong ball datapath.
// Holds the controller state enum, position width and direction codes.
package pong_pkg;

  localparam int POS_W = 8;

  localparam logic [POS_W-1:0] POS_CENTER = 8'd128;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    MISS
  } state_e;

  function automatic logic [POS_W-1:0] sat_inc(
    input logic [POS_W-1:0] v
  );
    return (v == '1) ? v : v + POS_W'(1);
  endfunction

endpackage

// File: rtl/ball_pos_ctrl_tick_gen.sv
// Programmable prescaler: pulses tick once every `period` enabled cycles.
// clr restarts the interval; the count freezes while en is low.
module tick_gen #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = en && (cnt_q == period - W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ball_pos_ctrl.sv
// Ball position controller: serve, step, paddle bounce and miss detection.
// Define BALL_SPEEDUP_EN to shorten the step period on every return.
module ball_pos_ctrl
  import pong_pkg::*;
#(
  parameter int               TICK_DIV   = 1000000,
  parameter logic [POS_W-1:0] LEFT_EDGE  = 8'd0,
  parameter logic [POS_W-1:0] RIGHT_EDGE = 8'd255,
  parameter int               SPEED_STEP = 62500,
  parameter int               MIN_DIV    = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serve_l,
  input  logic             serve_r,
  input  logic             hit_l,
  input  logic             hit_r,
  output logic [POS_W-1:0] ball_pos,
  output logic             ball_dir,
  output logic             moving,
  output logic             step,
  output logic             miss_l,
  output logic             miss_r,
  output logic [7:0]       rally_cnt
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] PER0 = CW'(TICK_DIV);

  state_e           state_q;
  logic [POS_W-1:0] pos_q;
  logic             dir_q;
  logic             moving_q;
  logic             step_q;
  logic             miss_l_q;
  logic             miss_r_q;
  logic [7:0]       rally_q;

  logic          tick;
  logic          run;
  logic          serve;
  logic          at_r;
  logic          at_l;
  logic          ret;
  logic [CW-1:0] period;

  assign run   = (state_q == MOVE);
  assign serve = (state_q == IDLE) && (serve_l || serve_r);
  assign at_r  = tick && (dir_q == DIR_RIGHT) && (pos_q == RIGHT_EDGE);
  assign at_l  = tick && (dir_q == DIR_LEFT) && (pos_q == LEFT_EDGE);
  assign ret   = (at_r && hit_r) || (at_l && hit_l);

`ifdef BALL_SPEEDUP_EN
  logic [CW-1:0] period_q;
  logic [CW-1:0] period_d;

  always_comb begin
    period_d = period_q;
    if (serve) begin
      period_d = PER0;
    end else if (ret) begin
      if (int'(period_q) >= MIN_DIV + SPEED_STEP) begin
        period_d = CW'(int'(period_q) - SPEED_STEP);
      end else begin
        period_d = CW'(MIN_DIV);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= PER0;
    end else begin
      period_q <= period_d;
    end
  end

  assign period = period_q;
`else
  assign period = PER0;
`endif

  tick_gen #(
    .W(CW)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (serve),
    .en    (run),
    .period(period),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pos_q    <= POS_CENTER;
      dir_q    <= DIR_RIGHT;
      moving_q <= 1'b0;
      step_q   <= 1'b0;
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
      rally_q  <= '0;
    end else begin
      step_q   <= 1'b0;
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (serve_l) begin
            state_q  <= MOVE;
            pos_q    <= LEFT_EDGE;
            dir_q    <= DIR_RIGHT;
            rally_q  <= '0;
            moving_q <= 1'b1;
          end else if (serve_r) begin
            state_q  <= MOVE;
            pos_q    <= RIGHT_EDGE;
            dir_q    <= DIR_LEFT;
            rally_q  <= '0;
            moving_q <= 1'b1;
          end
        end
        MOVE: begin
          if (ret) begin
            dir_q   <= ~dir_q;
            pos_q   <= at_r ? RIGHT_EDGE - POS_W'(1)
                            : LEFT_EDGE + POS_W'(1);
            rally_q <= sat_inc(rally_q);
            step_q  <= 1'b1;
          end else if (at_r || at_l) begin
            state_q  <= MISS;
            moving_q <= 1'b0;
            miss_r_q <= at_r;
            miss_l_q <= at_l;
          end else if (tick) begin
            pos_q  <= (dir_q == DIR_RIGHT) ? pos_q + POS_W'(1)
                                           : pos_q - POS_W'(1);
            step_q <= 1'b1;
          end
        end
        MISS: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ball_pos  = pos_q;
  assign ball_dir  = dir_q;
  assign moving    = moving_q;
  assign step      = step_q;
  assign miss_l    = miss_l_q;
  assign miss_r    = miss_r_q;
  assign rally_cnt = rally_q;

endmodule

// File: tb/tb_ball_pos_ctrl.sv
// Scoreboard bench for ball_pos_ctrl: a cycle model queues expectations.
// Build with BALL_SPEEDUP_EN to exercise the shrinking step period.
module tb_ball_pos_ctrl;

`ifdef BALL_SPEEDUP_EN
  localparam int TDIV = 8;
  localparam int G1   = 6;
  localparam int G2   = 4;
  localparam int G3   = 4;
`else
  localparam int TDIV = 4;
  localparam int G1   = 4;
  localparam int G2   = 4;
  localparam int G3   = 4;
`endif
  localparam int SSTEP = 2;
  localparam int MDIV  = 4;

  typedef struct packed {
    logic [7:0] pos;
    logic       dir;
    logic       mov;
    logic       stp;
    logic       ml;
    logic       mr;
    logic [7:0] rc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       serve_l;
  logic       serve_r;
  logic       hit_l;
  logic       hit_r;
  logic [7:0] ball_pos;
  logic       ball_dir;
  logic       moving;
  logic       step;
  logic       miss_l;
  logic       miss_r;
  logic [7:0] rally_cnt;

  always #5 clk = ~clk;

  ball_pos_ctrl #(
    .TICK_DIV  (TDIV),
    .LEFT_EDGE (8'd0),
    .RIGHT_EDGE(8'd255),
    .SPEED_STEP(SSTEP),
    .MIN_DIV   (MDIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .serve_l  (serve_l),
    .serve_r  (serve_r),
    .hit_l    (hit_l),
    .hit_r    (hit_r),
    .ball_pos (ball_pos),
    .ball_dir (ball_dir),
    .moving   (moving),
    .step     (step),
    .miss_l   (miss_l),
    .miss_r   (miss_r),
    .rally_cnt(rally_cnt)
  );

  int   n_run;
  int   n_fail;
  exp_t sbq[$];

  // Reference state: 0 idle, 1 move, 2 miss; m_left counts down to a step.
  int   m_st, m_pos, m_dir, m_rc, m_per, m_left;
  logic m_step, m_ml, m_mr;

  int cyc, last_step, gap, steps;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model(input logic r, sl, sr, hl, hr);
    m_step = 1'b0;
    m_ml   = 1'b0;
    m_mr   = 1'b0;
    if (r) begin
      m_st = 0; m_pos = 128; m_dir = 1; m_rc = 0;
      m_per = TDIV; m_left = 0;
    end else if (m_st == 0) begin
      if (sl || sr) begin
        m_st   = 1;
        m_pos  = sl ? 0 : 255;
        m_dir  = sl ? 1 : 0;
        m_rc   = 0;
        m_per  = TDIV;
        m_left = TDIV;
      end
    end else if (m_st == 2) begin
      m_st = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_dir == 1 && m_pos < 255) begin
          m_pos++; m_step = 1'b1;
        end else if (m_dir == 0 && m_pos > 0) begin
          m_pos--; m_step = 1'b1;
        end else if ((m_dir == 1 && hr) || (m_dir == 0 && hl)) begin
          m_pos  = (m_dir == 1) ? 254 : 1;
          m_dir  = 1 - m_dir;
          m_step = 1'b1;
          if (m_rc < 255) m_rc++;
`ifdef BALL_SPEEDUP_EN
          m_per = (m_per - SSTEP < MDIV) ? MDIV : m_per - SSTEP;
`endif
        end else begin
          m_st = 2;
          if (m_dir == 1) m_mr = 1'b1;
          else m_ml = 1'b1;
        end
        m_left = m_per;
      end
    end
  endtask

  task automatic drive(input logic r, sl, sr, hl, hr);
    exp_t e;
    rst = r; serve_l = sl; serve_r = sr; hit_l = hl; hit_r = hr;
    model(r, sl, sr, hl, hr);
    e.pos = 8'(m_pos);
    e.dir = m_dir[0];
    e.mov = (m_st == 1);
    e.stp = m_step;
    e.ml  = m_ml;
    e.mr  = m_mr;
    e.rc  = 8'(m_rc);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sbq.pop_front();
    chk("pos", ball_pos, e.pos);
    chk("dir", ball_dir, e.dir);
    chk("moving", moving, e.mov);
    chk("step", step, e.stp);
    chk("miss_l", miss_l, e.ml);
    chk("miss_r", miss_r, e.mr);
    chk("rally", rally_cnt, e.rc);
    if (step === 1'b1) begin
      gap = cyc - last_step;
      last_step = cyc;
      steps++;
    end
  endtask

  task automatic run_to(input int pos, input logic hl, hr);
    int k;
    k = 0;
    while (m_pos != pos && k < 400 * TDIV) begin
      drive(1'b0, 1'b0, 1'b0, hl, hr);
      k++;
    end
    if (m_pos != pos) chk("reach_tmo", ball_pos, pos);
  endtask

  task automatic wait_ev(input logic hl, hr);
    int k;
    k = 0;
    do begin
      drive(1'b0, 1'b0, 1'b0, hl, hr);
      k++;
    end while (!(m_step || m_ml || m_mr) && k < 4 * TDIV + 4);
    if (!(m_step || m_ml || m_mr)) chk("event_tmo", k, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_run = 0; n_fail = 0;
    cyc = 0; last_step = 0; gap = 0; steps = 0;
    rst = 1'b1; serve_l = 1'b0; serve_r = 1'b0;
    hit_l = 1'b0; hit_r = 1'b0;

    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_pos", ball_pos, 128);
    chk("idle_mov", moving, 0);
    chk("idle_steps", steps, 0);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    last_step = cyc;
    steps = 0;
    chk("srv_pos", ball_pos, 0);
    chk("srv_dir", ball_dir, 1);
    chk("srv_mov", moving, 1);
    repeat (TDIV - 1) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_step_pos", ball_pos, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_pos", ball_pos, 1);
    chk("first_gap", gap, TDIV);

    // Swings held high away from the edge must not matter.
    run_to(255, 1'b1, 1'b1);
    chk("steps255", steps, 255);
    wait_ev(1'b0, 1'b1);
    chk("ret_r_pos", ball_pos, 254);
    chk("ret_r_dir", ball_dir, 0);
    chk("ret_r_rc", rally_cnt, 1);

    run_to(0, 1'b0, 1'b0);
    wait_ev(1'b1, 1'b0);
    chk("ret_l_pos", ball_pos, 1);
    chk("ret_l_dir", ball_dir, 1);
    chk("ret_l_rc", rally_cnt, 2);

    run_to(77, 1'b0, 1'b0);
    chk("at77", ball_pos, 77);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_pos", ball_pos, 128);
    chk("rst_mov", moving, 0);
    chk("rst_rc", rally_cnt, 0);
    chk("rst_dir", ball_dir, 1);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("both_pos", ball_pos, 0);
    chk("both_dir", ball_dir, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mv_srv_pos", ball_pos, 0);
    chk("mv_srv_dir", ball_dir, 1);

    run_to(255, 1'b0, 1'b0);
    wait_ev(1'b0, 1'b0);
    chk("miss_r_hi", miss_r, 1);
    chk("miss_l_lo", miss_l, 0);
    chk("miss_pos", ball_pos, 255);
    chk("miss_mov", moving, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("miss_r_lo", miss_r, 0);
    chk("miss_srv_ign", moving, 0);
    chk("miss_hold_pos", ball_pos, 255);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    last_step = cyc;
    chk("srv_r_pos", ball_pos, 255);
    chk("srv_r_dir", ball_dir, 0);
    chk("srv_r_mov", moving, 1);

    run_to(0, 1'b0, 1'b0);
    wait_ev(1'b1, 1'b0);
    wait_ev(1'b0, 1'b0);
    chk("gap1", gap, G1);
    run_to(255, 1'b0, 1'b0);
    wait_ev(1'b0, 1'b1);
    wait_ev(1'b0, 1'b0);
    chk("gap2", gap, G2);
    run_to(0, 1'b0, 1'b0);
    wait_ev(1'b1, 1'b0);
    wait_ev(1'b0, 1'b0);
    chk("gap3", gap, G3);
    chk("rc3", rally_cnt, 3);

    run_to(255, 1'b0, 1'b0);
    wait_ev(1'b0, 1'b0);
    chk("miss2", miss_r, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    last_step = cyc;
    wait_ev(1'b0, 1'b0);
    chk("gap_reserve", gap, TDIV);
    chk("reserve_pos", ball_pos, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
